// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//
//   FETCH_XLEN    : default address/instruction width of the core.
//   INST_BYTES    : size of one instruction; the sequential PC step.
//   fetch_entry_t : one fetch-queue entry, {pc, ir}, at the default width.
//                   fetch_queue_stage declares the same layout at its own
//                   XLEN so the stage stays width-generic.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO holding fetched instructions until decode takes them.
//
//   Parameters
//     DEPTH   : number of entries (power of two, >= 2).
//     entry_t : stored element type.
//
//   Ports
//     clk, rst  : clock and synchronous active-high reset.
//     push      : write push_data at the tail (ignored when full, unless a
//                 pop happens in the same cycle).
//     push_data : element to write.
//     pop       : drop the head (ignored when empty).
//     flush     : empty the FIFO; wins over push and pop.
//     head      : current head element (valid only when !empty).
//     count     : occupancy, 0..DEPTH.
//     full      : count == DEPTH.
//     empty     : count == 0.
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is still legal when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset: contents are only observable through head while
    // count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage
//   In-order instruction fetch: issues sequential word fetches to memory,
//   buffers the returned instructions with their PCs, and hands them to
//   decode. A redirect flushes the queue and discards responses to requests
//   that were already in flight.
//
//   Handshakes: on both imem_req_* and if_* a transfer happens in exactly the
//   cycles where valid and ready are both 1 at the rising edge. valid never
//   depends on ready. imem_resp_valid has no ready: memory returns exactly
//   one response per accepted request, in request order, and the stage must
//   take it in that cycle.
//
//   Ports
//     clk, rst         : clock, synchronous active-high reset.
//     redirect_valid   : taken branch this cycle; redirect_pc is the target.
//     imem_req_valid   : fetch request valid (requires a free credit).
//     imem_req_ready   : memory accepts the request.
//     imem_req_addr    : word-aligned fetch address.
//     imem_resp_valid  : response valid; imem_resp_data is the instruction.
//     if_valid         : queue head valid toward decode.
//     if_ready         : decode accepts the head.
//     if_pc/if_npc     : PC of the head and PC + 4.
//     if_ir            : head instruction.
//     if_count         : queue occupancy.
// ---------------------------------------------------------------------------
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [XLEN-1:0]        imem_resp_data,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [XLEN-1:0]        if_pc,
    output logic [XLEN-1:0]        if_npc,
    output logic [XLEN-1:0]        if_ir,
    output logic [$clog2(DEPTH):0] if_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Same layout as fetch_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW:0]     credit_used;

    logic            req_fire;
    logic            resp_counted;
    logic            resp_drop;
    logic            q_push;
    logic            q_pop;
    entry_t          q_in;
    entry_t          q_head;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;

    // ---------------- request side ----------------
    // Every accepted request reserves a queue slot until decode pops it, so
    // inflight + count never exceeds DEPTH and the queue cannot overflow.
    assign credit_used    = {1'b0, inflight} + {1'b0, q_count};
    assign imem_req_valid = ~rst & ~redirect_valid & (credit_used < (CW+1)'(DEPTH));
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign imem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};

    // ---------------- response side ----------------
    // Responses with nothing in flight belong to requests issued before a
    // reset; they are ignored rather than allowed to underflow inflight.
    assign resp_counted = imem_resp_valid & (inflight != '0);
    assign resp_drop    = resp_counted & (redirect_valid | (drop_cnt != '0));

    assign q_pop  = if_valid & if_ready;
    assign q_push = resp_counted & ~resp_drop & (~q_full | q_pop);
    assign q_in   = '{pc: resp_pc, ir: imem_resp_data};

    always_comb begin
        inflight_next = inflight;
        if (req_fire && !resp_counted) begin
            inflight_next = inflight + CW'(1);
        end else if (!req_fire && resp_counted) begin
            inflight_next = inflight - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                // Everything still outstanding after this cycle is stale,
                // including requests whose drop was already pending.
                drop_cnt <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
                end
                if (q_push) begin
                    resp_pc <= resp_pc + XLEN'(INST_BYTES);
                end
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    // ---------------- queue toward decode ----------------
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Outputs come only from the registered head: an instruction returned in
    // cycle N is presented in cycle N+1. During a redirect the head is stale,
    // so it is hidden and any pop attempt that cycle has no effect.
    assign if_valid = ~rst & ~redirect_valid & ~q_empty;
    assign if_pc    = q_head.pc;
    assign if_npc   = q_head.pc + XLEN'(INST_BYTES);
    assign if_ir    = q_head.ir;
    assign if_count = rst ? '0 : q_count;

endmodule
